// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_fetch_if;
    logic        imem_req_o;
    logic [11:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC generation, in-order imem requests and a small
// {pc, inst} return buffer feeding IF/ID; redirects drop wrong-path responses.
module if_fetch #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [5:0]  flash,
    input  logic        branch_flag_i,
    input  logic [11:0] branch_target_i,
    if_fetch_if.master  imem,
    output logic [31:0] if_inst,
    output logic [11:0] pc_o,
    output logic        stallreq_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_CNT = DEPTH[CNT_W:0];

    logic [11:0]            fetch_pc_q, fetch_pc_d;
    logic [DEPTH-1:0][11:0] pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0]       pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic [DEPTH-1:0][11:0] buf_pc_q, buf_pc_d;
    logic [DEPTH-1:0][31:0] buf_inst_q, buf_inst_d;
    logic [PTR_W-1:0]       buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       discard_q, discard_d;

    logic redirect_c, credit_c, accept_c, rsp_c, push_c, pop_c;
    logic unused_ok_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered counts only: a pop frees a slot from the next cycle on.
    assign redirect_c       = branch_flag_i | flash[0];
    assign credit_c         = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_CNT;
    assign imem.imem_req_o  = rst & ~redirect_c & credit_c;
    assign imem.imem_addr_o = fetch_pc_q;
    assign accept_c         = imem.imem_req_o & imem.imem_gnt_i;
    assign rsp_c            = imem.imem_rvalid_i & (outst_q != '0);
    assign push_c           = rsp_c & ~redirect_c & (discard_q == '0);
    assign pop_c            = ~redirect_c & ~stall[1] & (count_q != '0);

    assign if_inst     = (count_q != '0) ? buf_inst_q[buf_rd_q] : '0;
    assign pc_o        = (count_q != '0) ? buf_pc_q[buf_rd_q] : '0;
    assign stallreq_o  = (count_q == '0);
    assign unused_ok_c = ^{stall[5:2], stall[0], flash[5:1], branch_target_i[1:0]};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_wr_d  = pend_wr_q;
        pend_rd_d  = pend_rd_q;
        outst_d    = outst_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        count_d    = count_q;
        discard_d  = discard_q;

        if (rsp_c) begin
            pend_rd_d = ptr_inc(pend_rd_q);
            outst_d   = outst_q - 1'b1;
        end

        if (redirect_c) begin
            // Everything still in flight belongs to the wrong path.
            fetch_pc_d = {branch_target_i[11:2], 2'b00};
            buf_wr_d   = '0;
            buf_rd_d   = '0;
            count_d    = '0;
            discard_d  = rsp_c ? outst_q - 1'b1 : outst_q;
        end else begin
            if (accept_c) begin
                pend_pc_d[pend_wr_q] = fetch_pc_q;
                pend_wr_d            = ptr_inc(pend_wr_q);
                fetch_pc_d           = fetch_pc_q + 12'd4;
                outst_d              = rsp_c ? outst_q : outst_q + 1'b1;
            end
            if (rsp_c && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push_c) begin
                buf_pc_d[buf_wr_q]   = pend_pc_q[pend_rd_q];
                buf_inst_d[buf_wr_q] = imem.imem_rdata_i;
                buf_wr_d             = ptr_inc(buf_wr_q);
            end
            if (pop_c) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + 1'b1;
            end else if (!push_c && pop_c) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            outst_q    <= '0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            count_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            outst_q    <= outst_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
        end
    end
endmodule
